// File: rtl/dport_axi_mo.sv
// dport_axi_mo
//   Bridge from the LSU data-cache request interface to an AXI4 master port.
//   Keeps up to MAX_OUTSTANDING transactions in flight on a single AXI ID and
//   buffers pending requests in a small queue. Responses return in request
//   order together with the tag supplied at request time. A change between
//   read and write direction waits until every in-flight transaction has been
//   acknowledged, so reads and writes never overlap on the bus.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   mem_*_i             request side: address, write data, read flag, byte
//                       strobes (nonzero = write), tag; cache-maintenance
//                       hints are accepted but ignored
//   mem_accept_o        request taken this cycle
//   mem_ack_o           response valid (combinational from bvalid/rvalid)
//   mem_error_o         response error
//   mem_data_rd_o       read data (passed straight from rdata)
//   mem_resp_tag_o      tag of the request being acknowledged
//   outstanding_o       number of issued, unacknowledged transactions
//   axi_aw*/w*/b*/ar*/r* AXI4 master channels (bready/rready tied high)
module dport_axi_mo #(
  parameter int REQ_DEPTH       = 2,
  parameter int REQ_ADDR_W      = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUTS_W          = 3,
  parameter int RESP_DEPTH      = 8,
  parameter int RESP_ADDR_W     = 3,
  parameter int TAG_W           = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_wr_i,
  input  logic              mem_rd_i,
  input  logic [3:0]        mem_wr_i,
  input  logic              mem_cacheable_i,
  input  logic [TAG_W-1:0]  mem_req_tag_i,
  input  logic              mem_invalidate_i,
  input  logic              mem_writeback_i,
  input  logic              mem_flush_i,
  output logic [31:0]       mem_data_rd_o,
  output logic              mem_accept_o,
  output logic              mem_ack_o,
  output logic              mem_error_o,
  output logic [TAG_W-1:0]  mem_resp_tag_o,
  output logic [OUTS_W-1:0] outstanding_o,
  output logic              axi_awvalid_o,
  output logic [31:0]       axi_awaddr_o,
  input  logic              axi_awready_i,
  output logic              axi_wvalid_o,
  output logic [31:0]       axi_wdata_o,
  output logic [3:0]        axi_wstrb_o,
  input  logic              axi_wready_i,
  input  logic              axi_bvalid_i,
  input  logic [1:0]        axi_bresp_i,
  output logic              axi_bready_o,
  output logic              axi_arvalid_o,
  output logic [31:0]       axi_araddr_o,
  input  logic              axi_arready_i,
  input  logic              axi_rvalid_i,
  input  logic [31:0]       axi_rdata_i,
  input  logic [1:0]        axi_rresp_i,
  output logic              axi_rready_o
);

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_e;

  typedef struct packed {
    dir_e        dir;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [29:0] addr;
  } req_t;

  // Request queue = registered head entry + REQ_DEPTH-deep buffer behind it,
  // giving REQ_DEPTH+1 requests of storage before back-pressure.
  req_t                  head_q, head_d;
  logic                  head_vld_q, head_vld_d;
  req_t                  buf_q [REQ_DEPTH];
  req_t                  buf_d [REQ_DEPTH];
  logic [REQ_ADDR_W-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  logic [REQ_ADDR_W:0]   buf_cnt_q, buf_cnt_d;

  logic [TAG_W-1:0]      tag_q [RESP_DEPTH];
  logic [TAG_W-1:0]      tag_d [RESP_DEPTH];
  logic [RESP_ADDR_W:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [OUTS_W-1:0]     out_cnt_q, out_cnt_d;
  dir_e                  last_dir_q, last_dir_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;

  logic req_vld, req_full, tag_full, push;
  logic head_load, buf_push, buf_pop;
  logic eligible, head_rd, head_wr;
  logic aw_hs, w_hs, issue, ack, ack_ok;
  req_t new_req;

  logic unused_ok;
  assign unused_ok = ^{mem_cacheable_i, mem_invalidate_i, mem_writeback_i,
                       mem_flush_i, mem_addr_i[1:0]};

  always_comb begin
    req_vld      = mem_rd_i | (|mem_wr_i);
    req_full     = head_vld_q & (buf_cnt_q == (REQ_ADDR_W+1)'(REQ_DEPTH));
    tag_full     = (tag_wr_q - tag_rd_q) == (RESP_ADDR_W+1)'(RESP_DEPTH);
    mem_accept_o = ~req_full & ~tag_full;
    push         = req_vld & mem_accept_o;

    new_req      = '0;
    new_req.dir  = mem_rd_i ? DIR_RD : DIR_WR;
    new_req.strb = mem_wr_i;
    new_req.data = mem_data_wr_i;
    new_req.addr = mem_addr_i[31:2];

    eligible = head_vld_q & (out_cnt_q < OUTS_W'(MAX_OUTSTANDING)) &
               ((out_cnt_q == '0) | (head_q.dir == last_dir_q));
    head_rd  = eligible & (head_q.dir == DIR_RD);
    head_wr  = eligible & (head_q.dir == DIR_WR);

    axi_arvalid_o = head_rd;
    axi_awvalid_o = head_wr & ~aw_done_q;
    axi_wvalid_o  = head_wr & ~w_done_q;
    axi_araddr_o  = {head_q.addr, 2'b00};
    axi_awaddr_o  = {head_q.addr, 2'b00};
    axi_wdata_o   = head_q.data;
    axi_wstrb_o   = head_q.strb;
    axi_bready_o  = 1'b1;
    axi_rready_o  = 1'b1;

    aw_hs = axi_awvalid_o & axi_awready_i;
    w_hs  = axi_wvalid_o & axi_wready_i;
    issue = (head_rd & axi_arready_i) |
            (head_wr & (aw_done_q | aw_hs) & (w_done_q | w_hs));

    // Both valids together count as one ack; B wins for the error flag.
    // An ack with nothing outstanding is ignored beyond the mem_ack_o pulse.
    ack            = axi_bvalid_i | axi_rvalid_i;
    ack_ok         = ack & (out_cnt_q != '0);
    mem_ack_o      = ack;
    mem_error_o    = axi_bvalid_i ? (axi_bresp_i != 2'b00) : (axi_rresp_i != 2'b00);
    mem_data_rd_o  = axi_rdata_i;
    mem_resp_tag_o = tag_q[tag_rd_q[RESP_ADDR_W-1:0]];
    outstanding_o  = out_cnt_q;

    // A new request goes straight into the head register only when the
    // buffer is empty and the head slot is free (or being vacated now).
    head_load = push & (~head_vld_q | issue) & (buf_cnt_q == '0);
    buf_push  = push & ~head_load;
    buf_pop   = issue & (buf_cnt_q != '0);
  end

  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    buf_d      = buf_q;
    buf_rd_d   = buf_rd_q;
    buf_wr_d   = buf_wr_q;
    buf_cnt_d  = buf_cnt_q;
    tag_d      = tag_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    out_cnt_d  = out_cnt_q;
    last_dir_d = last_dir_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;

    if (issue) begin
      head_vld_d = 1'b0;
      last_dir_d = head_q.dir;
    end
    if (buf_pop) begin
      head_d     = buf_q[buf_rd_q];
      head_vld_d = 1'b1;
      buf_rd_d   = buf_rd_q + REQ_ADDR_W'(1);
    end
    if (head_load) begin
      head_d     = new_req;
      head_vld_d = 1'b1;
    end
    if (buf_push) begin
      buf_d[buf_wr_q] = new_req;
      buf_wr_d        = buf_wr_q + REQ_ADDR_W'(1);
    end
    case ({buf_push, buf_pop})
      2'b10:   buf_cnt_d = buf_cnt_q + (REQ_ADDR_W+1)'(1);
      2'b01:   buf_cnt_d = buf_cnt_q - (REQ_ADDR_W+1)'(1);
      default: buf_cnt_d = buf_cnt_q;
    endcase

    if (push) begin
      tag_d[tag_wr_q[RESP_ADDR_W-1:0]] = mem_req_tag_i;
      tag_wr_d = tag_wr_q + (RESP_ADDR_W+1)'(1);
    end
    if (ack_ok) begin
      tag_rd_d = tag_rd_q + (RESP_ADDR_W+1)'(1);
    end

    case ({issue, ack_ok})
      2'b10:   out_cnt_d = out_cnt_q + OUTS_W'(1);
      2'b01:   out_cnt_d = out_cnt_q - OUTS_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    // Each write channel is masked once it has handshaken ahead of the other.
    if (issue) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      aw_done_d = aw_done_q | aw_hs;
      w_done_d  = w_done_q | w_hs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
      for (int unsigned i = 0; i < REQ_DEPTH; i++) buf_q[i] <= '0;
      buf_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_cnt_q  <= '0;
      for (int unsigned i = 0; i < RESP_DEPTH; i++) tag_q[i] <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      out_cnt_q  <= '0;
      last_dir_q <= DIR_RD;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      buf_q      <= buf_d;
      buf_rd_q   <= buf_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_cnt_q  <= buf_cnt_d;
      tag_q      <= tag_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      out_cnt_q  <= out_cnt_d;
      last_dir_q <= last_dir_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule
